// File: rtl/tetris_sequencer_if.sv
// Command, response and row-clear channel between tetris_sequencer (master)
// and the board engine (slave).
interface tetris_sequencer_if;
    // A command transfers on the cycle cmd_valid && cmd_ready. Once raised,
    // cmd_valid stays high with cmd_spawn/cmd_op/cmd_type stable until that
    // cycle, and only an async reset may withdraw it early. The engine answers
    // every accepted command with exactly one rsp_valid pulse.
    logic       cmd_valid;
    logic       cmd_spawn;
    logic [1:0] cmd_op;
    logic [2:0] cmd_type;
    logic       cmd_ready;
    logic       rsp_valid;
    logic       rsp_blocked;
    logic       clear_start;
    logic       clear_done;

    modport master (
        output cmd_valid, cmd_spawn, cmd_op, cmd_type, clear_start,
        input  cmd_ready, rsp_valid, rsp_blocked, clear_done
    );

    modport slave (
        input  cmd_valid, cmd_spawn, cmd_op, cmd_type, clear_start,
        output cmd_ready, rsp_valid, rsp_blocked, clear_done
    );
endinterface

// File: rtl/tetris_sequencer.sv
// Game-phase scheduler for the 8x8 tetris engine: merges gravity and player ops
// onto a single-outstanding command channel. Optional pause: TETRIS_SEQ_PAUSE_EN.
module tetris_sequencer #(
    parameter int GRAVITY_DIV = 333,
    parameter int REPEAT_DIV  = 150,
    parameter int NUM_TYPES   = 7
) (
    input  logic       clk_1000,
    input  logic       restart_n,
    input  logic       start,
    input  logic [3:0] op,
`ifdef TETRIS_SEQ_PAUSE_EN
    input  logic       pause,
`endif
    tetris_sequencer_if.master bus,
    output logic       score_inc,
    output logic       game_active,
    output logic       game_over,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SPAWN  = 3'd1,
        S_PLAY   = 3'd2,
        S_ISSUE  = 3'd3,
        S_WAIT   = 3'd4,
        S_CLEAR  = 3'd5,
        S_OVER   = 3'd6
`ifdef TETRIS_SEQ_PAUSE_EN
        , S_PAUSED = 3'd7
`endif
    } state_t;

    localparam logic [1:0] OP_DOWN   = 2'd0;
    localparam logic [1:0] OP_LEFT   = 2'd1;
    localparam logic [1:0] OP_RIGHT  = 2'd2;
    localparam logic [1:0] OP_ROTATE = 2'd3;

    localparam logic [1:0] SRC_SPAWN = 2'd0;
    localparam logic [1:0] SRC_GRAV  = 2'd1;
    localparam logic [1:0] SRC_USER  = 2'd2;

    state_t      state;
    state_t      state_next;
    logic [2:0]  type_cnt;
    logic [2:0]  cmd_type_q;
    logic [1:0]  cmd_op_q;
    logic [1:0]  src_q;
    logic [15:0] grav_cnt;
    logic        grav_pend;
    logic [15:0] rep_cnt;
    logic [3:0]  op_prev;
    logic        pend_valid;
    logic [1:0]  pend_op;
    logic [1:0]  op_code;
    logic        op_onehot;
    logic        op_held;
    logic        op_req;
    logic        pause_hit;
    logic        in_group;
    logic        take_grav;
    logic        take_user;
    logic        spawn_done;
    logic        lock;

`ifdef TETRIS_SEQ_PAUSE_EN
    logic pause_prev;

    always_ff @(posedge clk_1000 or negedge restart_n) begin
        if (!restart_n) pause_prev <= 1'b0;
        else            pause_prev <= pause;
    end

    assign pause_hit = pause && !pause_prev;
`else
    assign pause_hit = 1'b0;
`endif

    always_comb begin
        op_code = OP_DOWN;
        case (op)
            4'b0001: op_code = OP_RIGHT;
            4'b0010: op_code = OP_ROTATE;
            4'b0100: op_code = OP_DOWN;
            4'b1000: op_code = OP_LEFT;
            default: op_code = OP_DOWN;
        endcase
    end

    // A held button repeats every REPEAT_DIV cycles, counted from its edge.
    assign op_onehot = $onehot(op);
    assign op_held   = op_onehot && (op == op_prev);
    assign op_req    = (op_onehot && (op != op_prev)) ||
                       (op_held && (rep_cnt == 16'(REPEAT_DIV - 1)));

    assign in_group   = (state == S_PLAY) || (state == S_ISSUE) || (state == S_WAIT);
    assign take_grav  = (state == S_PLAY) && !pause_hit && grav_pend;
    assign take_user  = (state == S_PLAY) && !pause_hit && !grav_pend && pend_valid;
    assign spawn_done = (state == S_SPAWN) && bus.cmd_ready;

    always_ff @(posedge clk_1000 or negedge restart_n) begin
        if (!restart_n) begin
            op_prev <= 4'd0;
            rep_cnt <= 16'd0;
        end else begin
            op_prev <= op;
            if (!op_held || (rep_cnt == 16'(REPEAT_DIV - 1))) rep_cnt <= 16'd0;
            else                                              rep_cnt <= rep_cnt + 16'd1;
        end
    end

    // A newer request overwrites an unissued one; nothing survives outside play.
    always_ff @(posedge clk_1000 or negedge restart_n) begin
        if (!restart_n) begin
            pend_valid <= 1'b0;
            pend_op    <= OP_DOWN;
        end else if (!in_group) begin
            pend_valid <= 1'b0;
        end else if (op_req) begin
            pend_valid <= 1'b1;
            pend_op    <= op_code;
        end else if (take_user) begin
            pend_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_1000 or negedge restart_n) begin
        if (!restart_n) begin
            grav_cnt  <= 16'd0;
            grav_pend <= 1'b0;
        end else if (spawn_done) begin
            grav_cnt  <= 16'd0;
            grav_pend <= 1'b0;
        end else begin
            if (in_group) begin
                if (grav_cnt == 16'(GRAVITY_DIV - 1)) grav_cnt <= 16'd0;
                else                                  grav_cnt <= grav_cnt + 16'd1;
            end
            if (in_group && (grav_cnt == 16'(GRAVITY_DIV - 1))) grav_pend <= 1'b1;
            else if (take_grav)                                 grav_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk_1000 or negedge restart_n) begin
        if (!restart_n) begin
            type_cnt   <= 3'd0;
            cmd_type_q <= 3'd0;
            cmd_op_q   <= OP_DOWN;
            src_q      <= SRC_SPAWN;
        end else begin
            if (type_cnt == 3'(NUM_TYPES - 1)) type_cnt <= 3'd0;
            else                               type_cnt <= type_cnt + 3'd1;
            if ((state_next == S_SPAWN) && (state != S_SPAWN)) cmd_type_q <= type_cnt;
            if (state == S_SPAWN) begin
                src_q <= SRC_SPAWN;
            end else if (take_grav) begin
                src_q    <= SRC_GRAV;
                cmd_op_q <= OP_DOWN;
            end else if (take_user) begin
                src_q    <= SRC_USER;
                cmd_op_q <= pend_op;
            end
        end
    end

    always_ff @(posedge clk_1000 or negedge restart_n) begin
        if (!restart_n) state <= S_IDLE;
        else            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_SPAWN;
            S_SPAWN: if (bus.cmd_ready) state_next = S_WAIT;
            S_PLAY: begin
`ifdef TETRIS_SEQ_PAUSE_EN
                if (pause_hit) state_next = S_PAUSED;
                else
`endif
                if (grav_pend || pend_valid) state_next = S_ISSUE;
            end
            S_ISSUE: if (bus.cmd_ready) state_next = S_WAIT;
            S_WAIT: begin
                if (bus.rsp_valid) begin
                    if ((src_q == SRC_SPAWN) && bus.rsp_blocked)     state_next = S_OVER;
                    else if ((src_q == SRC_GRAV) && bus.rsp_blocked) state_next = S_CLEAR;
                    else                                             state_next = S_PLAY;
                end
            end
            S_CLEAR: if (bus.clear_done) state_next = S_SPAWN;
            S_OVER:  if (start) state_next = S_SPAWN;
`ifdef TETRIS_SEQ_PAUSE_EN
            S_PAUSED: if (pause_hit) state_next = S_PLAY;
`endif
            default: state_next = S_IDLE;
        endcase
    end

    // A blocked gravity DOWN means the piece has landed: score it and clear rows.
    assign lock = (state == S_WAIT) && bus.rsp_valid && bus.rsp_blocked && (src_q == SRC_GRAV);

    always_comb begin
        bus.cmd_valid   = (state == S_SPAWN) || (state == S_ISSUE);
        bus.cmd_spawn   = (state == S_SPAWN);
        bus.cmd_op      = cmd_op_q;
        bus.cmd_type    = cmd_type_q;
        bus.clear_start = lock;
        score_inc       = lock;
        game_over       = (state == S_OVER);
        game_active     = (state == S_SPAWN) || (state == S_PLAY) || (state == S_ISSUE) ||
                          (state == S_WAIT)  || (state == S_CLEAR);
`ifdef TETRIS_SEQ_PAUSE_EN
        if (state == S_PAUSED) game_active = 1'b1;
`endif
        dbg_state       = state;
    end

endmodule

// File: tb/tb_tetris_sequencer.sv
// Directed bench for tetris_sequencer: expected commands (cycle, kind, op, type)
// are queued by each test and popped by a handshake monitor.
module tb_tetris_sequencer;

    logic       clk = 1'b0;
    logic       restart_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] op = 4'd0;
`ifdef TETRIS_SEQ_PAUSE_EN
    logic       pause = 1'b0;
`endif
    logic       score_inc;
    logic       game_active;
    logic       game_over;
    logic [2:0] dbg_state;

    tetris_sequencer_if bus();

    tetris_sequencer #(.GRAVITY_DIV(8), .REPEAT_DIV(150), .NUM_TYPES(7)) dut (
        .clk_1000    (clk),
        .restart_n   (restart_n),
        .start       (start),
        .op          (op),
`ifdef TETRIS_SEQ_PAUSE_EN
        .pause       (pause),
`endif
        .bus         (bus),
        .score_inc   (score_inc),
        .game_active (game_active),
        .game_over   (game_over),
        .dbg_state   (dbg_state)
    );

    localparam logic [1:0] DOWN  = 2'd0;
    localparam logic [1:0] RIGHT = 2'd2;

    int          cyc = 0;
    int          rel_cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          score_cnt = 0;
    int          clear_cnt = 0;
    int          score_cyc = 0;
    int          clear_cyc = 0;
    logic        block_spawn = 1'b0;
    logic        block_grav = 1'b0;
    logic [37:0] exp_q[$];

    // clock / cycle counter
    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [2:0] exp_type(input int n);
        return 3'((n - rel_cyc) % 7);
    endfunction

    task automatic push_cmd(input int c, input logic sp, input logic [1:0] o, input logic [2:0] t);
        logic [31:0] cw;
        cw = c;
        exp_q.push_back({cw, sp, o, t});
    endtask

    task automatic do_reset();
        restart_n = 1'b0;
        start = 1'b0;
        op = 4'd0;
        bus.cmd_ready = 1'b1;
        block_spawn = 1'b0;
        block_grav = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        score_cnt = 0;
        clear_cnt = 0;
        check("rst_cmd_valid", bus.cmd_valid, 0);
        check("rst_cmd_spawn", bus.cmd_spawn, 0);
        check("rst_cmd_op", bus.cmd_op, 0);
        check("rst_cmd_type", bus.cmd_type, 0);
        check("rst_clear_start", bus.clear_start, 0);
        check("rst_score_inc", score_inc, 0);
        check("rst_game_active", game_active, 0);
        check("rst_game_over", game_over, 0);
        check("rst_state", dbg_state, 0);
        restart_n = 1'b1;
        rel_cyc = cyc;
    endtask

    task automatic drain_check(input string name);
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // scoreboard monitor: every accepted command pops one expectation
    initial begin
        logic [37:0] e;
        forever begin
            @(negedge clk);
            if (restart_n && bus.cmd_valid && bus.cmd_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_cmd: spawn=%0d op=%0d at cycle %0d, none required",
                             bus.cmd_spawn, bus.cmd_op, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("cmd_cycle", cyc, e[37:6]);
                    check("cmd_spawn", bus.cmd_spawn, e[5]);
                    check("cmd_op", bus.cmd_op, e[4:3]);
                    if (e[5]) check("cmd_type", bus.cmd_type, e[2:0]);
                end
            end
        end
    end

    // engine model: one response in the cycle after each handshake
    initial begin
        logic blk;
        bus.rsp_valid = 1'b0;
        bus.rsp_blocked = 1'b0;
        forever begin
            @(negedge clk);
            if (restart_n && bus.cmd_valid && bus.cmd_ready) begin
                blk = 1'b0;
                if (bus.cmd_spawn && block_spawn) begin
                    blk = 1'b1;
                    block_spawn = 1'b0;
                end else if (!bus.cmd_spawn && (bus.cmd_op == DOWN) && block_grav) begin
                    blk = 1'b1;
                    block_grav = 1'b0;
                end
                @(posedge clk); #1;
                bus.rsp_valid = 1'b1;
                bus.rsp_blocked = blk;
                @(posedge clk); #1;
                bus.rsp_valid = 1'b0;
                bus.rsp_blocked = 1'b0;
            end
        end
    end

    // row-clear model: clear_done five cycles after clear_start
    initial begin
        bus.clear_done = 1'b0;
        forever begin
            @(negedge clk);
            if (restart_n && bus.clear_start) begin
                repeat (5) @(posedge clk);
                #1 bus.clear_done = 1'b1;
                @(posedge clk);
                #1 bus.clear_done = 1'b0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (score_inc) begin score_cnt++; score_cyc = cyc; end
        if (bus.clear_start) begin clear_cnt++; clear_cyc = cyc; end
    end

    initial begin
        int p;
        int q;

        // A: spawn, gravity every 8 cycles, multi-hot ignored, held DOWN repeats
        do_reset();
        goto(rel_cyc + 3);
        p = cyc;
        start = 1'b1;
        push_cmd(p + 1, 1'b1, DOWN, exp_type(p));
        for (int c = p + 2; c <= p + 429; c++) begin
            if ((c - p - 11) >= 0 && ((c - p - 11) % 8) == 0) push_cmd(c, 1'b0, DOWN, 3'd0);
            else if (c == p + 24 || c == p + 174 || c == p + 326) push_cmd(c, 1'b0, DOWN, 3'd0);
        end
        goto(p + 1);  start = 1'b0;
        goto(p + 5);
        check("play_game_active", game_active, 1);
        check("play_state", dbg_state, 2);
        goto(p + 13); op = 4'b0110;
        goto(p + 16); op = 4'b0000;
        goto(p + 22); op = 4'b0100;
        goto(p + 422); op = 4'b0000;
        goto(p + 430);
        drain_check("drain_repeat");

        // B: gravity tick and RIGHT edge together; gravity first
        do_reset();
        goto(rel_cyc + 3);
        p = cyc;
        start = 1'b1;
        push_cmd(p + 1, 1'b1, DOWN, exp_type(p));
        push_cmd(p + 11, 1'b0, DOWN, 3'd0);
        push_cmd(p + 19, 1'b0, DOWN, 3'd0);
        push_cmd(p + 22, 1'b0, RIGHT, 3'd0);
        push_cmd(p + 27, 1'b0, DOWN, 3'd0);
        goto(p + 1);  start = 1'b0;
        goto(p + 17); op = 4'b0001;
        goto(p + 20); op = 4'b0000;
        goto(p + 30);
        drain_check("drain_priority");

        // C: blocked gravity DOWN locks, clears rows, respawns
        do_reset();
        goto(rel_cyc + 3);
        p = cyc;
        start = 1'b1;
        block_grav = 1'b1;
        push_cmd(p + 1, 1'b1, DOWN, exp_type(p));
        push_cmd(p + 11, 1'b0, DOWN, 3'd0);
        push_cmd(p + 18, 1'b1, DOWN, exp_type(p + 17));
        push_cmd(p + 28, 1'b0, DOWN, 3'd0);
        push_cmd(p + 36, 1'b0, DOWN, 3'd0);
        goto(p + 1);  start = 1'b0;
        goto(p + 15);
        check("clear_state", dbg_state, 5);
        check("clear_game_active", game_active, 1);
        goto(p + 38);
        check("score_count", score_cnt, 1);
        check("clear_count", clear_cnt, 1);
        check("score_cycle", score_cyc, p + 12);
        check("clear_cycle", clear_cyc, p + 12);
        drain_check("drain_lock");

        // D: blocked spawn ends the game; start begins a new one
        do_reset();
        goto(rel_cyc + 3);
        p = cyc;
        start = 1'b1;
        block_spawn = 1'b1;
        push_cmd(p + 1, 1'b1, DOWN, exp_type(p));
        goto(p + 1);  start = 1'b0;
        goto(p + 5);
        check("over_game_over", game_over, 1);
        check("over_game_active", game_active, 0);
        check("over_cmd_valid", bus.cmd_valid, 0);
        goto(p + 20);
        check("over_idle_valid", bus.cmd_valid, 0);
        q = cyc;
        start = 1'b1;
        push_cmd(q + 1, 1'b1, DOWN, exp_type(q));
        push_cmd(q + 11, 1'b0, DOWN, 3'd0);
        goto(q + 1);  start = 1'b0;
        check("restart_game_over", game_over, 0);
        goto(q + 13);
        drain_check("drain_over");

        // E: stalled command holds steady; async reset drops it at once
        do_reset();
        goto(rel_cyc + 3);
        p = cyc;
        start = 1'b1;
        push_cmd(p + 1, 1'b1, DOWN, exp_type(p));
        goto(p + 1);  start = 1'b0;
        goto(p + 2);  bus.cmd_ready = 1'b0;
        for (int c = p + 11; c <= p + 20; c++) begin
            goto(c);
            @(negedge clk);
            check("stall_valid", bus.cmd_valid, 1);
            check("stall_spawn", bus.cmd_spawn, 0);
            check("stall_op", bus.cmd_op, DOWN);
            check("stall_state", dbg_state, 3);
        end
        #2 restart_n = 1'b0;
        #1;
        check("async_cmd_valid", bus.cmd_valid, 0);
        check("async_game_active", game_active, 0);
        check("async_cmd_type", bus.cmd_type, 0);
        check("async_state", dbg_state, 0);
        drain_check("drain_stall");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
